decrypt_key_schedule: RTL and testbench

DECRYPT_KEY_SCHEDULE -- requirements
Module: decrypt_key_schedule

---
 rtl/decrypt_key_schedule.sv | 184 ++++++++++++++++++
 tb/tb_decrypt_key_schedule.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_key_schedule.sv
// ---------------------------------------------------------------------------
// decrypt_key_schedule
//   Expands an AES-128 cipher key into its 11 round keys, one key per clock,
//   and then streams them to the decrypt round datapath in reverse order
//   (round 10 first, round 0 last). After round 0 the stream wraps back to
//   round 10, so the same schedule serves any number of blocks.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-high reset
//   key_in     : 128-bit cipher key, bits [127:120] = byte 0
//   key_load   : start expansion of key_in (sampled on the rising edge)
//   busy       : expansion in progress
//   keys_ready : all 11 round keys stored, streaming enabled
//   rk_out     : round key currently offered to the consumer
//   rk_valid   : rk_out holds a valid round key
//   rk_ready   : consumer accepts rk_out
//   rk_index   : round number of rk_out (10 down to 0)
//   rk_last    : rk_out is the round-0 key (final AddRoundKey)
// ---------------------------------------------------------------------------
module decrypt_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_ready,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic         rk_last
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  logic [1:0]   state;
  logic [3:0]   round;
  logic [3:0]   ptr;
  logic [127:0] keyStore [0:10];

  logic [3:0]   prevIdx;
  logic [127:0] prevKey;
  logic [127:0] nextKey;
  logic [31:0]  rotW3;
  logic [31:0]  subW3;
  logic [31:0]  temp;
  logic [31:0]  w0New;
  logic [31:0]  w1New;
  logic [31:0]  w2New;
  logic [31:0]  w3New;
  logic         transfer;

  // Round constant for rounds 1..10; unused rounds map to zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Next-key datapath: one full round key per cycle from the previous slot.
  assign prevIdx = round - 4'd1;
  assign prevKey = keyStore[prevIdx];
  assign rotW3   = {prevKey[23:0], prevKey[31:24]};

  for (genvar g = 0; g < 4; g++) begin : gSubWord
    aes_sbox uSbox (
      .inByte  (rotW3[8*g +: 8]),
      .outByte (subW3[8*g +: 8])
    );
  end

  assign temp    = subW3 ^ {rcon(round), 24'h0};
  assign w0New   = prevKey[127:96] ^ temp;
  assign w1New   = prevKey[95:64]  ^ w0New;
  assign w2New   = prevKey[63:32]  ^ w1New;
  assign w3New   = prevKey[31:0]   ^ w2New;
  assign nextKey = {w0New, w1New, w2New, w3New};

  assign transfer = (state == READY) && rk_ready;

  // Control: state, round counter and stream pointer.
  // key_load has priority over everything, including a simultaneous transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= 4'd0;
      ptr   <= LAST_ROUND;
    end else if (key_load) begin
      state <= EXPAND;
      round <= 4'd1;
    end else begin
      case (state)
        EXPAND: begin
          round <= round + 4'd1;
          if (round == LAST_ROUND) begin
            state <= READY;
            ptr   <= LAST_ROUND;
          end
        end
        READY: begin
          if (transfer) begin
            ptr <= (ptr == 4'd0) ? LAST_ROUND : ptr - 4'd1;
          end
        end
        IDLE: ;
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key store: data only, contents are meaningless until a load.
  always_ff @(posedge clk) begin
    if (key_load) begin
      keyStore[0] <= key_in;
    end else if (state == EXPAND) begin
      keyStore[round] <= nextKey;
    end
  end

  // Outputs decode directly from state so reset clears them immediately.
  // rk_out/rk_index are forced to zero outside READY to keep them free of X.
  assign busy       = (state == EXPAND);
  assign keys_ready = (state == READY);
  assign rk_valid   = (state == READY);
  assign rk_out     = rk_valid ? keyStore[ptr] : 128'h0;
  assign rk_index   = rk_valid ? ptr : 4'd0;
  assign rk_last    = rk_valid && (ptr == 4'd0);

endmodule

// ---------------------------------------------------------------------------
// aes_sbox
//   Forward AES S-box, purely combinational table lookup.
//
// Ports
//   inByte  : input byte
//   outByte : S-box substitution of inByte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] inByte,
  output logic [7:0] outByte
);

  // Entry 0 sits in the top byte; entry i lives at bits [8*(255-i) +: 8],
  // and 255-i is simply the bitwise inverse of i.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign outByte = SBOX_TABLE[{~inByte, 3'b000} +: 8];

endmodule

// File: tb/tb_decrypt_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_decrypt_key_schedule
//   Self-checking bench for decrypt_key_schedule. The reference schedule is
//   computed with the textbook word-by-word AES-128 key expansion, using an
//   S-box derived from GF(2^8) inversion plus the affine transform.
// ---------------------------------------------------------------------------
module tb_decrypt_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         keys_ready;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic         rk_last;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0]   sboxRef [0:255];
  logic [127:0] refKeys [0:10];

  decrypt_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_index   (rk_index),
    .rk_last    (rk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandRef(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxRef[t[31:24]], sboxRef[t[23:16]], sboxRef[t[15:8]], sboxRef[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadKey(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Counts cycles from the load edge (inclusive) until keys_ready shows.
  task automatic waitReady(input string tag);
    int cycles;
    cycles = 1;
    while (!keys_ready && cycles < 40) begin
      tick();
      cycles++;
    end
    check(tag, 128'(cycles), 128'd11);
  endtask

  // Streams n keys with rk_ready held high, starting from index 10.
  task automatic streamCheck(input int n, input string tag);
    int expPtr;
    expPtr   = 10;
    rk_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 128'(rk_valid), 128'd1);
      check({tag, "_index"}, 128'(rk_index), 128'(expPtr));
      check({tag, "_key"},   rk_out, refKeys[expPtr]);
      check({tag, "_last"},  128'(rk_last), 128'(expPtr == 0));
      tick();
      expPtr = (expPtr == 0) ? 10 : expPtr - 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] keyA;
    logic [127:0] keyB;
    logic [127:0] prevOut;
    logic [3:0]   prevIdx;
    logic         held;
    logic         rr;
    int           expPtr;
    int           passes;
    int           cyc;
    int           validSeen;

    rst      = 1'b1;
    key_in   = '0;
    key_load = 1'b0;
    rk_ready = 1'b0;
    buildSbox();
    #1;
    check("rst_busy",   128'(busy), 128'd0);
    check("rst_ready",  128'(keys_ready), 128'd0);
    check("rst_valid",  128'(rk_valid), 128'd0);
    check("rst_last",   128'(rk_last), 128'd0);
    check("rst_index",  128'(rk_index), 128'd0);
    check("rst_out",    rk_out, 128'd0);
    tick();
    rst = 1'b0;
    tick();

    // FIPS-197 appendix A key
    keyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expandRef(keyA);
    rk_ready = 1'b1;
    loadKey(keyA);
    check("t1_busy", 128'(busy), 128'd1);
    check("t1_valid_exp", 128'(rk_valid), 128'd0);
    waitReady("t1_latency");
    check("t1_busy_done", 128'(busy), 128'd0);
    check("t1_first_const", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    streamCheck(10, "t1");
    check("t1_last_key", rk_out, keyA);
    check("t1_last_flag", 128'(rk_last), 128'd1);
    tick();
    check("t1_wrap_index", 128'(rk_index), 128'd10);

    // FIPS-197 appendix C.1 key, full pass plus wrap
    keyA = 128'h000102030405060708090a0b0c0d0e0f;
    expandRef(keyA);
    loadKey(keyA);
    waitReady("t2_latency");
    check("t2_first_const", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    streamCheck(12, "t2");

    // Random key with random consumer throttling over three passes
    keyA = {$urandom, $urandom, $urandom, $urandom};
    expandRef(keyA);
    rk_ready = 1'b0;
    loadKey(keyA);
    waitReady("t3_latency");
    expPtr = 10;
    passes = 0;
    cyc    = 0;
    held   = 1'b0;
    prevOut = '0;
    prevIdx = '0;
    while (passes < 3 && cyc < 1000) begin
      check("t3_valid", 128'(rk_valid), 128'd1);
      check("t3_index", 128'(rk_index), 128'(expPtr));
      check("t3_key", rk_out, refKeys[expPtr]);
      if (held) begin
        check("t3_hold_key", rk_out, prevOut);
        check("t3_hold_index", 128'(rk_index), 128'(prevIdx));
      end
      rr       = 1'($urandom_range(0, 1));
      rk_ready = rr;
      held     = !rr;
      prevOut  = rk_out;
      prevIdx  = rk_index;
      if (rr) begin
        if (expPtr == 0) begin
          expPtr = 10;
          passes++;
        end else begin
          expPtr--;
        end
      end
      tick();
      cyc++;
    end
    check("t3_passes", 128'(passes), 128'd3);

    // Reload with key B during expansion of key A (B sampled at E5)
    keyA = {$urandom, $urandom, $urandom, $urandom};
    keyB = {$urandom, $urandom, $urandom, $urandom};
    rk_ready = 1'b1;
    loadKey(keyA);
    repeat (4) tick();
    check("t4_busy_mid", 128'(busy), 128'd1);
    expandRef(keyB);
    loadKey(keyB);
    waitReady("t4_latency");
    streamCheck(11, "t4");

    // Reset mid-stream at index 6
    streamCheck(4, "t5pre");
    check("t5_index6", 128'(rk_index), 128'd6);
    rst = 1'b1;
    #1;
    check("t5_rst_busy",  128'(busy), 128'd0);
    check("t5_rst_ready", 128'(keys_ready), 128'd0);
    check("t5_rst_valid", 128'(rk_valid), 128'd0);
    check("t5_rst_last",  128'(rk_last), 128'd0);
    check("t5_rst_index", 128'(rk_index), 128'd0);
    check("t5_rst_out",   rk_out, 128'd0);
    #1;
    rst = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rk_valid || busy) validSeen++;
    end
    check("t5_idle_after_rst", 128'(validSeen), 128'd0);
    keyA = {$urandom, $urandom, $urandom, $urandom};
    expandRef(keyA);
    loadKey(keyA);
    waitReady("t5_latency");
    streamCheck(3, "t5");

    // key_load coincident with a transfer in READY
    keyB = {$urandom, $urandom, $urandom, $urandom};
    expandRef(keyB);
    rk_ready = 1'b1;
    loadKey(keyB);
    check("t6_busy", 128'(busy), 128'd1);
    check("t6_valid", 128'(rk_valid), 128'd0);
    check("t6_ready", 128'(keys_ready), 128'd0);
    waitReady("t6_latency");
    streamCheck(11, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
